product_tc_restore: RTL and testbench

- Downstream neighbour of the operand two's-complement stage and the Urdhva-Tiryakbhyam vector multiplier core.
- Takes the unsigned 64-bit magnitude product, the per-byte sign flags of both operands, the precision and the opcode.
- Restores the signed product per lane and selects the low or high half of each lane product to form the 32-bit vector result.
- Two-stage pipeline with a valid/ready handshake on both sides.

---
 rtl/product_tc_restore.sv | 121 ++++++++++++
 tb/tb_product_tc_restore.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_tc_restore.sv
// Restores signed lane products from the unsigned multiplier magnitude and
// selects the low or high half of each lane into a packed 32-bit result.
module product_tc_restore #(
    parameter bit PIPE_REG_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] product,
    input  logic [3:0]  sign_a,
    input  logic [3:0]  sign_b,
    input  logic [1:0]  precision,
    input  logic [1:0]  opcode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [1:0]  out_precision
);

    logic        s1_valid;
    logic [63:0] s1_prod;
    logic [1:0]  s1_prec;
    logic [1:0]  s1_op;
    logic [63:0] restored;
    logic [31:0] packed_res;
    logic [3:0]  neg;
    logic        adv2;

    assign neg = sign_a ^ sign_b;

    // Each lane is negated within its own double-width field; no cross-lane carry.
    always_comb begin
        restored = product;
        unique case (1'b1)
            precision == 2'b10: begin
                if (neg[3])
                    restored = -product;
            end
            precision == 2'b01: begin
                for (int j = 0; j < 2; j++) begin
                    if (neg[2*j+1])
                        restored[32*j +: 32] = -product[32*j +: 32];
                end
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    if (neg[i])
                        restored[16*i +: 16] = -product[16*i +: 16];
                end
            end
        endcase
    end

    always_comb begin
        packed_res = '0;
        unique case (1'b1)
            s1_prec == 2'b10: begin
                packed_res = (s1_op == 2'b00) ? s1_prod[31:0] : s1_prod[63:32];
            end
            s1_prec == 2'b01: begin
                for (int j = 0; j < 2; j++) begin
                    packed_res[16*j +: 16] = (s1_op == 2'b00)
                        ? s1_prod[32*j +: 16]
                        : s1_prod[32*j+16 +: 16];
                end
            end
            default: begin
                for (int i = 0; i < 4; i++) begin
                    packed_res[8*i +: 8] = (s1_op == 2'b00)
                        ? s1_prod[16*i +: 8]
                        : s1_prod[16*i+8 +: 8];
                end
            end
        endcase
    end

    assign in_ready = !s1_valid || adv2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_prec  <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_prod <= restored;
                s1_prec <= precision;
                s1_op   <= opcode;
            end
        end
    end

    generate
        if (PIPE_REG_OUT) begin : g_reg_out
            assign adv2 = !out_valid || out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid     <= 1'b0;
                    result        <= '0;
                    out_precision <= '0;
                end else if (adv2) begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        result        <= packed_res;
                        out_precision <= s1_prec;
                    end
                end
            end
        end else begin : g_comb_out
            assign adv2          = out_ready;
            assign out_valid     = s1_valid;
            assign result        = packed_res;
            assign out_precision = s1_prec;
        end
    endgenerate

endmodule

// File: tb/tb_product_tc_restore.sv
// Randomised and directed checks of product_tc_restore against a
// lane-arithmetic reference model with an in-order scoreboard.
module tb_product_tc_restore;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] product;
    logic [3:0]  sign_a;
    logic [3:0]  sign_b;
    logic [1:0]  precision;
    logic [1:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [1:0]  out_precision;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_res_q[$];
    logic [1:0]  exp_prec_q[$];
    logic        held = 1'b0;
    logic [31:0] held_res;
    logic [1:0]  held_prec;

    always #5 clk = ~clk;

    product_tc_restore dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .product(product),
        .sign_a(sign_a),
        .sign_b(sign_b),
        .precision(precision),
        .opcode(opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .out_precision(out_precision)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lane-wise signed restore using plain modular arithmetic.
    function automatic logic [31:0] model(input logic [63:0] p,
                                          input logic [3:0] sa,
                                          input logic [3:0] sb,
                                          input logic [1:0] prec,
                                          input logic [1:0] op);
        int w;
        int n;
        logic [127:0] m;
        logic [127:0] half;
        logic [127:0] lp;
        logic [31:0] r;
        int sidx;
        w = (prec == 2'b01) ? 16 : (prec == 2'b10) ? 32 : 8;
        n = 32 / w;
        m = 128'd1 << (2 * w);
        half = 128'd1 << w;
        r = '0;
        for (int i = 0; i < n; i++) begin
            lp = (128'(p) >> (2 * w * i)) % m;
            sidx = i * (w / 8) + (w / 8 - 1);
            if (sa[sidx] ^ sb[sidx])
                lp = (m - lp) % m;
            lp = (op == 2'b00) ? (lp % half) : (lp / half);
            r = r | 32'(lp << (w * i));
        end
        return r;
    endfunction

    // One cycle: drive at negedge, observe handshakes, then let posedge fire.
    task automatic step(input logic iv, input logic [63:0] p,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input logic [1:0] prec, input logic [1:0] op,
                        input logic ordy, output logic acc,
                        output logic rdy);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = iv;
        product   = p;
        sign_a    = sa;
        sign_b    = sb;
        precision = prec;
        opcode    = op;
        out_ready = ordy;
        #1;
        if (held) begin
            check_eq("hold_result", 64'(result), 64'(held_res));
            check_eq("hold_prec", 64'(out_precision), 64'(held_prec));
        end
        if (out_valid && out_ready) begin
            if (exp_res_q.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                check_eq("result", 64'(result), 64'(exp_res_q.pop_front()));
                check_eq("out_prec", 64'(out_precision),
                         64'(exp_prec_q.pop_front()));
            end
        end
        held      = out_valid && !out_ready;
        held_res  = result;
        held_prec = out_precision;
        acc = in_valid && in_ready;
        rdy = in_ready;
        if (acc) begin
            exp_res_q.push_back(model(p, sa, sb, prec, op));
            exp_prec_q.push_back(prec);
        end
    endtask

    task automatic directed(input string tag, input logic [63:0] p,
                            input logic [3:0] sa, input logic [3:0] sb,
                            input logic [1:0] prec, input logic [1:0] op,
                            input logic [31:0] mask,
                            input logic [31:0] exp);
        logic acc;
        logic rdy;
        step(1'b1, p, sa, sb, prec, op, 1'b1, acc, rdy);
        check_eq({tag, "_accept"}, 64'(acc), 64'(1));
        step(1'b0, '0, '0, '0, '0, '0, 1'b1, acc, rdy);
        check_eq({tag, "_lat1"}, 64'(out_valid), 64'(0));
        step(1'b0, '0, '0, '0, '0, '0, 1'b1, acc, rdy);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'(1));
        check_eq(tag, 64'(result & mask), 64'(exp));
    endtask

    initial begin
        logic acc;
        logic rdy;
        int k;
        int cyc;
        logic [63:0] bp_p[4];
        logic [3:0]  bp_sa[4];
        logic [3:0]  bp_sb[4];
        logic [1:0]  bp_pr[4];
        logic [1:0]  bp_op[4];

        rst = 1'b1;
        in_valid = 1'b0;
        product = '0;
        sign_a = '0;
        sign_b = '0;
        precision = '0;
        opcode = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_result", 64'(result), 64'(0));
        check_eq("rst_out_prec", 64'(out_precision), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));

        directed("mul8_lo", 64'hF, 4'b0001, 4'b0000, 2'b00, 2'b00,
                 32'hFF, 32'hF1);
        directed("mul8_hi", 64'hF, 4'b0001, 4'b0000, 2'b00, 2'b01,
                 32'hFF, 32'hFF);
        directed("mul32_lo", 64'h1, 4'b1000, 4'b1000, 2'b10, 2'b00,
                 32'hFFFF_FFFF, 32'h1);
        directed("mul32_hi", 64'h1, 4'b1000, 4'b1000, 2'b10, 2'b01,
                 32'hFFFF_FFFF, 32'h0);
        directed("mulhu16", 64'h0000_0000_FFFE_0001, 4'b0, 4'b0, 2'b01,
                 2'b10, 32'hFFFF, 32'hFFFE);
        directed("mix16", 64'h0000_0006_0000_0006, 4'b0010, 4'b0000, 2'b01,
                 2'b00, 32'hFFFF_FFFF, 32'h0006_FFFA);

        // Backpressure: four beats, consumer stalled for the first 3 cycles.
        for (int i = 0; i < 4; i++) begin
            bp_p[i]  = {$urandom, $urandom};
            bp_sa[i] = 4'($urandom);
            bp_sb[i] = 4'($urandom);
            bp_pr[i] = 2'($urandom);
            bp_op[i] = 2'($urandom);
        end
        k = 0;
        cyc = 0;
        while ((k < 4 || exp_res_q.size() != 0) && cyc < 30) begin
            if (k < 4)
                step(1'b1, bp_p[k], bp_sa[k], bp_sb[k], bp_pr[k], bp_op[k],
                     cyc >= 3, acc, rdy);
            else
                step(1'b0, '0, '0, '0, '0, '0, 1'b1, acc, rdy);
            if (cyc == 2) begin
                check_eq("bp_accepts", 64'(k), 64'(2));
                check_eq("bp_in_ready", 64'(rdy), 64'(0));
            end
            if (acc)
                k++;
            cyc++;
        end
        check_eq("bp_timeout", 64'(cyc < 30), 64'(1));

        // Reset with both stages full.
        step(1'b1, 64'h1234, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, acc, rdy);
        step(1'b1, 64'h5678, 4'h0, 4'h0, 2'b00, 2'b00, 1'b0, acc, rdy);
        step(1'b0, '0, '0, '0, '0, '0, 1'b0, acc, rdy);
        check_eq("full_before_rst", 64'({out_valid, in_ready}), 64'(2'b10));
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("midrst_result", 64'(result), 64'(0));
        check_eq("midrst_in_ready", 64'(in_ready), 64'(1));
        exp_res_q.delete();
        exp_prec_q.delete();
        held = 1'b0;
        directed("post_rst", 64'h0000_0000_0000_0019, 4'b0100, 4'b0000,
                 2'b00, 2'b00, 32'hFFFF_FFFF, 32'h0000_0019);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), {$urandom, $urandom}, 4'($urandom),
                 4'($urandom), 2'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) != 0), acc, rdy);
        end
        cyc = 0;
        while (exp_res_q.size() != 0 && cyc < 10) begin
            step(1'b0, '0, '0, '0, '0, '0, 1'b1, acc, rdy);
            cyc++;
        end
        check_eq("drain_empty", 64'(exp_res_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
